// File: rtl/noc_packet_sink.sv
// Local-port packet receiver: checks header/tail framing, drops and counts malformed
// flits, and buffers well-formed flits in a small FIFO drained through a valid/ready stream.
module noc_packet_sink #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 4,
  parameter logic [7:0]  LOCAL_ID   = 8'h00
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [DATA_WIDTH-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_flit,
  output logic                  out_is_header,
  output logic                  out_is_tail,
  output logic [15:0]           pkt_count,
  output logic [15:0]           err_count,
  output logic                  err_pulse
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BODY} state_t;

  typedef struct packed {
    logic                  is_header;
    logic                  is_tail;
    logic [DATA_WIDTH-1:0] flit;
  } entry_t;

  state_t          state, state_next;
  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fifo_count;
  logic            acc, pop, push, pkt_inc, misroute;
  logic [1:0]      err_inc;

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign receive_ready = (fifo_count != (AW+1)'(DEPTH));
  assign out_valid     = (fifo_count != '0);
  assign acc           = receive_valid & receive_ready;
  assign pop           = out_valid & out_ready;
  assign misroute      = (receive_flit[DATA_WIDTH-1 -: 8] != LOCAL_ID);

  // Head is gated so a drained or freshly reset FIFO presents all-zero outputs.
  assign head          = mem[rd_ptr];
  assign out_flit      = out_valid ? head.flit      : '0;
  assign out_is_header = out_valid ? head.is_header : 1'b0;
  assign out_is_tail   = out_valid ? head.is_tail   : 1'b0;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_next = state;
    push       = 1'b0;
    pkt_inc    = 1'b0;
    err_inc    = 2'd0;
    if (acc) begin
      if (receive_is_header) begin
        // A header inside a packet truncates it; the header still starts a new packet.
        push       = 1'b1;
        err_inc    = {1'b0, state == BODY} + {1'b0, misroute};
        pkt_inc    = receive_is_tail;
        state_next = receive_is_tail ? IDLE : BODY;
      end else if (state == BODY) begin
        push    = 1'b1;
        pkt_inc = receive_is_tail;
        if (receive_is_tail) state_next = IDLE;
      end else begin
        err_inc = 2'd1;
      end
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!noc_rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      pkt_count  <= '0;
      err_count  <= '0;
      err_pulse  <= 1'b0;
    end else begin
      state     <= state_next;
      pkt_count <= sat_add(pkt_count, {1'b0, pkt_inc});
      err_count <= sat_add(err_count, err_inc);
      err_pulse <= (err_inc != 2'd0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an empty count plus the output gating hides stale entries.
  always_ff @(posedge noc_clk) begin
    if (push) mem[wr_ptr] <= '{is_header: receive_is_header, is_tail: receive_is_tail, flit: receive_flit};
  end

endmodule

// File: tb/tb_noc_packet_sink.sv
// Directed bench for noc_packet_sink: a queue-based model checked every cycle,
// plus hand-computed expectations at the end of each scenario.
module tb_noc_packet_sink;

  localparam int         DW    = 32;
  localparam int         DEPTH = 4;
  localparam logic [7:0] LID   = 8'h00;

  logic          noc_clk = 1'b0;
  logic          noc_rst_n = 1'b0;
  logic          receive_valid = 1'b0;
  logic          receive_ready;
  logic [DW-1:0] receive_flit = '0;
  logic          receive_is_header = 1'b0;
  logic          receive_is_tail = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_flit;
  logic          out_is_header;
  logic          out_is_tail;
  logic [15:0]   pkt_count;
  logic [15:0]   err_count;
  logic          err_pulse;

  noc_packet_sink #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LOCAL_ID(LID)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .receive_valid(receive_valid), .receive_ready(receive_ready),
    .receive_flit(receive_flit), .receive_is_header(receive_is_header),
    .receive_is_tail(receive_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .pkt_count(pkt_count), .err_count(err_count), .err_pulse(err_pulse)
  );

  always #5 noc_clk = ~noc_clk;

  int tests_run = 0;
  int tests_failed = 0;
  int pulse_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {logic h; logic t; logic [DW-1:0] f;} ent_t;
  ent_t mq[$];
  bit   m_in_pkt;
  int   m_pkt, m_err, m_e;
  bit   m_pulse, m_room, m_pop;

  always @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      mq.delete();
      m_in_pkt = 0; m_pkt = 0; m_err = 0; m_pulse = 0;
    end else begin
      m_room = mq.size() < DEPTH;
      m_pop  = out_ready && mq.size() > 0;
      m_e    = 0;
      if (receive_valid && m_room) begin
        if (receive_is_header) begin
          if (m_in_pkt) m_e++;
          if (receive_flit[DW-1 -: 8] != LID) m_e++;
          mq.push_back('{h: 1'b1, t: receive_is_tail, f: receive_flit});
          m_in_pkt = !receive_is_tail;
          if (receive_is_tail) m_pkt = (m_pkt < 65535) ? m_pkt + 1 : 65535;
        end else if (m_in_pkt) begin
          mq.push_back('{h: 1'b0, t: receive_is_tail, f: receive_flit});
          if (receive_is_tail) begin
            m_in_pkt = 0;
            m_pkt = (m_pkt < 65535) ? m_pkt + 1 : 65535;
          end
        end else begin
          m_e = 1;
        end
      end
      if (m_pop) void'(mq.pop_front());
      m_err   = (m_err + m_e > 65535) ? 65535 : m_err + m_e;
      m_pulse = (m_e != 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge noc_clk) begin
    if (noc_rst_n) begin
      check("receive_ready", receive_ready, mq.size() < DEPTH);
      check("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0)
        check("out_head", {out_is_header, out_is_tail, out_flit}, {mq[0].h, mq[0].t, mq[0].f});
      else
        check("out_idle_zero", {out_is_header, out_is_tail, out_flit}, '0);
      check("pkt_count", pkt_count, m_pkt);
      check("err_count", err_count, m_err);
      check("err_pulse", err_pulse, m_pulse);
      if (err_pulse) pulse_seen++;
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [DW-1:0] f, input logic h, input logic t);
    int n;
    receive_flit = f; receive_is_header = h; receive_is_tail = t; receive_valid = 1'b1;
    n = 0;
    while (!receive_ready && n < 200) begin
      @(negedge noc_clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 1'b1, 1'b0);
    @(negedge noc_clk);
  endtask

  task automatic idle();
    receive_valid = 1'b0; receive_is_header = 1'b0; receive_is_tail = 1'b0; receive_flit = '0;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b0;
    noc_rst_n = 1'b0;
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    pulse_seen = 0;
  endtask

  initial begin
    repeat (2) @(negedge noc_clk);
    check("rst_receive_ready", receive_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_fields", {out_is_header, out_is_tail, out_flit}, '0);
    check("rst_counts", {pkt_count, err_count, err_pulse}, '0);
    noc_rst_n = 1'b1;

    // 1: four-flit packet streamed straight through
    out_ready = 1'b1;
    send(32'h00A0_0001, 1'b1, 1'b0);
    check("lat_out_valid", out_valid, 1'b1);
    check("lat_out_flit", out_flit, 32'h00A0_0001);
    send(32'h00A0_0002, 1'b0, 1'b0);
    send(32'h00A0_0003, 1'b0, 1'b0);
    send(32'h00A0_0004, 1'b0, 1'b1);
    idle();
    repeat (3) @(negedge noc_clk);
    check("t1_pkt", pkt_count, 16'd1);
    check("t1_err", err_count, 16'd0);

    // 2: back-pressure with six flits into a four-deep FIFO
    do_reset();
    fork
      begin
        send(32'h00B0_0001, 1'b1, 1'b0);
        for (int i = 2; i <= 5; i++) send(32'h00B0_0000 + i, 1'b0, 1'b0);
        send(32'h00B0_0006, 1'b0, 1'b1);
        idle();
      end
      begin
        repeat (8) @(negedge noc_clk);
        check("t2_full_ready", receive_ready, 1'b0);
        check("t2_full_head", out_flit, 32'h00B0_0001);
        out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge noc_clk);
    check("t2_pkt", pkt_count, 16'd1);
    check("t2_drained", out_valid, 1'b0);

    // 3: two orphans, then a single-flit packet
    do_reset();
    out_ready = 1'b1;
    send(32'h00C0_0001, 1'b0, 1'b0);
    send(32'h00C0_0002, 1'b0, 1'b0);
    send(32'h00C0_0003, 1'b1, 1'b1);
    check("t3_flags", {out_is_header, out_is_tail, out_flit}, {2'b11, 32'h00C0_0003});
    idle();
    repeat (3) @(negedge noc_clk);
    check("t3_err", err_count, 16'd2);
    check("t3_pkt", pkt_count, 16'd1);
    check("t3_pulses", pulse_seen, 2);

    // 4: missing tail
    do_reset();
    out_ready = 1'b1;
    send(32'h00D0_0001, 1'b1, 1'b0);
    send(32'h00D0_0002, 1'b0, 1'b0);
    send(32'h00D0_0003, 1'b1, 1'b0);
    send(32'h00D0_0004, 1'b0, 1'b1);
    idle();
    repeat (3) @(negedge noc_clk);
    check("t4_err", err_count, 16'd1);
    check("t4_pkt", pkt_count, 16'd1);

    // 5: misrouted header
    do_reset();
    out_ready = 1'b1;
    send(32'h11E0_0001, 1'b1, 1'b0);
    send(32'h00E0_0002, 1'b0, 1'b1);
    idle();
    repeat (3) @(negedge noc_clk);
    check("t5_err", err_count, 16'd1);
    check("t5_pkt", pkt_count, 16'd1);

    // 6: reset in the middle of a packet
    do_reset();
    send(32'h00F0_0001, 1'b1, 1'b0);
    send(32'h00F0_0002, 1'b0, 1'b0);
    idle();
    check("t6_pre_valid", out_valid, 1'b1);
    #2 noc_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_counts", {pkt_count, err_count}, '0);
    check("t6_rst_ready", receive_ready, 1'b1);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h00F0_0003, 1'b0, 1'b1);
    idle();
    repeat (2) @(negedge noc_clk);
    check("t6_err", err_count, 16'd1);
    check("t6_pkt", pkt_count, 16'd0);
    check("t6_empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
